// File: rtl/hex_word_tx_sched.sv
// hex_word_tx_sched: round-robin share of one UART byte stream between two
// 32-bit requesters, each word sent as uppercase ASCII hex plus optional CR/LF.
module hex_word_tx_sched #(
    parameter int NIBBLES   = 8,
    parameter bit TERM_CRLF = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] a_data,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [31:0] b_data,
    input  logic        b_valid,
    output logic        b_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        last_src
);

    typedef enum logic [1:0] {
        IDLE,
        SEND_HEX,
        SEND_CR,
        SEND_LF
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(NIBBLES - 1);
    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;

    state_t      state;
    state_t      state_n;
    logic [31:0] word;
    logic [31:0] word_n;
    logic [2:0]  cnt;
    logic [2:0]  cnt_n;
    logic [2:0]  cnt_dec;
    logic [7:0]  data_n;
    logic        valid_n;
    logic        last_n;
    logic        grant_a;
    logic        grant_b;
    logic        take;
    logic [31:0] sel_data;

    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        logic [7:0] ext;
        ext = {4'h0, v};
        if (v < 4'd10) begin
            return ext + 8'h30;
        end
        return ext + 8'h37;
    endfunction

    function automatic logic [3:0] nib(input logic [31:0] w,
                                       input logic [2:0]  i);
        return w[{i, 2'b00} +: 4];
    endfunction

    assign busy    = (state != IDLE);
    assign cnt_dec = cnt - 3'd1;

    // Round-robin grant; ready pulses only in IDLE and never during reset.
    always_comb begin
        grant_a = a_valid && (!b_valid || last_src);
        grant_b = b_valid && (!a_valid || !last_src);
        take    = rstn && (state == IDLE);
        a_ready = take && grant_a;
        b_ready = take && grant_b;
        sel_data = b_ready ? b_data : a_data;
    end

    // Next-state and next-output logic for the byte sequencer.
    always_comb begin
        state_n = state;
        word_n  = word;
        cnt_n   = cnt;
        data_n  = tx_data;
        valid_n = tx_valid;
        last_n  = last_src;
        unique case (state)
            IDLE: begin
                if (a_ready || b_ready) begin
                    word_n  = sel_data;
                    last_n  = b_ready;
                    cnt_n   = CNT_INIT;
                    data_n  = hex_ascii(nib(sel_data, CNT_INIT));
                    valid_n = 1'b1;
                    state_n = SEND_HEX;
                end
            end
            SEND_HEX: begin
                if (tx_ready) begin
                    if (cnt != 3'd0) begin
                        cnt_n  = cnt_dec;
                        data_n = hex_ascii(nib(word, cnt_dec));
                    end else if (TERM_CRLF) begin
                        data_n  = CHAR_CR;
                        state_n = SEND_CR;
                    end else begin
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            SEND_CR: begin
                if (tx_ready) begin
                    data_n  = CHAR_LF;
                    state_n = SEND_LF;
                end
            end
            SEND_LF: begin
                if (tx_ready) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                valid_n = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // State, captured word and registered UART outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            word     <= '0;
            cnt      <= '0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            last_src <= 1'b1;
        end else begin
            state    <= state_n;
            word     <= word_n;
            cnt      <= cnt_n;
            tx_data  <= data_n;
            tx_valid <= valid_n;
            last_src <= last_n;
        end
    end

endmodule

// File: doc/hex_word_tx_sched.md
Name: hex_word_tx_sched

Overview:
- Shares one byte-wide UART transmit path between two 32-bit requesters (A, B) using round-robin arbitration.
- Captures the granted word and converts its nibbles to uppercase ASCII hex, most-significant digit first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46).
- Streams the digits, plus an optional CR/LF terminator, over a valid/ready byte handshake into the UART transmitter.
- Sits between the keyboard/debug data sources and uart_tx on the board top level.

Parameters:
- NIBBLES, 8: hex digits sent per word, legal range 1..8. The low NIBBLES nibbles of the word are sent, MSB first.
- TERM_CRLF, 1: when 1, append 0x0D then 0x0A after the digits; when 0, send no terminator.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- a_data  in  32  requester A word.
- a_valid  in  1  requester A has a word.
- a_ready  out  1  A word accepted this cycle.
- b_data  in  32  requester B word.
- b_valid  in  1  requester B has a word.
- b_ready  out  1  B word accepted this cycle.
- tx_data  out  8  ASCII byte to UART.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART accepts byte.
- busy  out  1  high in every state except IDLE.
- last_src  out  1  source of the most recent grant (0 = A, 1 = B).

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rstn); all state clears immediately on rstn low.
- Reset values:
  - state = IDLE; tx_valid = 0; tx_data = 0x00; busy = 0; last_src = 1 (so A wins the first contest).
  - a_ready = b_ready = 0 while in reset.
- States: IDLE, SEND_HEX, SEND_CR, SEND_LF.
- IDLE, grant:
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the source != last_src.
  - a_ready/b_ready are combinational, high only in IDLE for the granted source, so at most one is high per cycle.
- IDLE, capture:
  - On the grant edge, capture the word and set last_src.
  - Load digit counter = NIBBLES-1.
  - Register tx_data = ASCII of nibble[counter] and tx_valid = 1, then go to SEND_HEX.
  - First byte is visible the cycle after the handshake (1-cycle latency).
- SEND_HEX:
  - tx_data and tx_valid are held stable while tx_valid && !tx_ready.
  - On tx_ready: if counter > 0, decrement and present the next digit in the following cycle (back-to-back, no bubble).
  - If counter == 0: go to SEND_CR with tx_data = 0x0D when TERM_CRLF = 1; otherwise drop tx_valid and go to IDLE.
- SEND_CR: on tx_ready, present 0x0A and go to SEND_LF.
- SEND_LF: on tx_ready, drop tx_valid and go to IDLE.
- Requesters are never granted outside IDLE; their valids may stay high and must not be dropped by this block.
- Throughput with tx_ready held high:
  - One byte per cycle.
  - Each word costs NIBBLES + 2·TERM_CRLF transfer cycles plus 1 IDLE grant cycle.
  - Consecutive words therefore show exactly one tx_valid-low cycle between them.
- Captured data is unaffected by requester data changing after the grant.
- Reset mid-operation: the in-flight byte and word are discarded, tx_valid drops asynchronously, and there is no resume after release.
- Nibble-to-ASCII conversion: add 0x30 for values 0-9, add 0x37 for values 10-15; 8-bit arithmetic with no overflow.

Test Plan:
- Single word: A sends 0x1234ABCD, tx_ready = 1 → bytes 31 32 33 34 41 42 43 44 0D 0A on 10 consecutive cycles; a_ready high 1 cycle; busy high 10 cycles.
- Back-pressure: B sends 0x0000000F, tx_ready toggles 1/0 → tx_data held during stalls, sequence 30×7 46 0D 0A, and no byte is lost or duplicated.
- Arbitration: A = 0x11111111 and B = 0x22222222 both continuously valid → after reset the grant order is A, B, A, B; last_src follows 0, 1, 0, 1.
- Parameters: NIBBLES = 2, TERM_CRLF = 0, word 0xFFFFFF9E → bytes 39 45 only, then return to IDLE.
- Reset mid-word: rstn low after the 3rd byte of 0xDEADBEEF → tx_valid = 0 immediately; after release, a new A word 0x00000001 emits 30×7 31 0D 0A.
- Data change after grant: A changes a_data the cycle after a_ready → output still matches the captured word.
